// File: rtl/reu_pkg.sv
// Shared transfer-type codes, sequencer states and per-byte access ordering
// for the REU transfer sequencer.
package reu_pkg;

    localparam logic [1:0] TT_STASH  = 2'd0;
    localparam logic [1:0] TT_FETCH  = 2'd1;
    localparam logic [1:0] TT_SWAP   = 2'd2;
    localparam logic [1:0] TT_VERIFY = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        C64_RD,
        C64_WR,
        RAM_RD,
        RAM_WR,
        GAP
    } state_t;

    function automatic state_t first_access(input logic [1:0] tt);
        return (tt == TT_FETCH) ? RAM_RD : C64_RD;
    endfunction

    // The access whose ack closes a byte.
    function automatic logic is_last(input state_t s, input logic [1:0] tt);
        case (tt)
            TT_STASH:          return s == RAM_WR;
            TT_FETCH, TT_SWAP: return s == C64_WR;
            default:           return s == RAM_RD;
        endcase
    endfunction

    // Only meaningful for accesses that do not close the byte.
    function automatic state_t next_access(input state_t s, input logic [1:0] tt);
        case (s)
            C64_RD:  return (tt == TT_STASH) ? RAM_WR : RAM_RD;
            RAM_RD:  return (tt == TT_FETCH) ? C64_WR : RAM_WR;
            RAM_WR:  return C64_WR;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/reu_bus_port.sv
// One four-phase req/ack bus master: registers address, write data and
// direction on go, drops req and captures read data when ack is seen.
module reu_bus_port #(
    parameter int   A_W     = 16,
    parameter logic DIR_RST = 1'b0,
    parameter logic RD_DIR  = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           go,
    input  logic [A_W-1:0] addr_in,
    input  logic [7:0]     data_in,
    input  logic           dir_in,
    input  logic           ack,
    input  logic [7:0]     q,
    output logic           req,
    output logic [A_W-1:0] addr,
    output logic [7:0]     data,
    output logic           dir,
    output logic [7:0]     rdata,
    output logic           ack_seen
);

    assign ack_seen = req & ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            req  <= 1'b0;
            addr <= '0;
            data <= '0;
            dir  <= DIR_RST;
        end else if (go) begin
            req  <= 1'b1;
            addr <= addr_in;
            data <= data_in;
            dir  <= dir_in;
        end else if (ack_seen) begin
            req  <= 1'b0;
        end
    end

    // Write acks must not clobber a byte still waiting to be written back.
    always_ff @(posedge clk) begin
        if (ack_seen && dir == RD_DIR)
            rdata <= q;
    end

endmodule

// File: rtl/reu_transfer_sequencer.sv
// Executes one REU stash/fetch/swap/verify transfer byte by byte over the
// C64 DMA port and the expansion RAM port.
module reu_transfer_sequencer
    import reu_pkg::*;
#(
    parameter int ram_a_bits = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            ttype,
    input  logic [15:0]           c64_a_in,
    input  logic [ram_a_bits-1:0] ram_a_in,
    input  logic [15:0]           len_in,
    input  logic                  fix_c64,
    input  logic                  fix_ram,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [15:0]           c64_a_cur,
    output logic [ram_a_bits-1:0] ram_a_cur,
    output logic [15:0]           len_cur,
    output logic [15:0]           dma_a,
    output logic [7:0]            dma_d,
    input  logic [7:0]            dma_q,
    output logic                  dma_rw,
    output logic                  dma_req,
    input  logic                  dma_ack,
    output logic [ram_a_bits-1:0] ram_a,
    output logic [7:0]            ram_d,
    input  logic [7:0]            ram_q,
    output logic                  ram_we,
    output logic                  ram_req,
    input  logic                  ram_ack
);

    localparam logic [ram_a_bits-1:0] RAM_ONE = 1;

    state_t state, state_n, after_gap, after_n, acc;
    logic [1:0] tt;
    logic fix_c64_q, fix_ram_q;
    logic dma_seen, ram_seen, ack_now, byte_end, mismatch, finish, launch;
    logic go_c64, go_ram;
    logic [7:0] dma_rdata, ram_rdata;
    logic [15:0] c64_addr_next;
    logic [ram_a_bits-1:0] ram_addr_next;

    reu_bus_port #(.A_W(16), .DIR_RST(1'b1), .RD_DIR(1'b1)) u_c64_port (
        .clk(clk), .reset(reset), .go(go_c64), .addr_in(c64_addr_next),
        .data_in(ram_rdata), .dir_in(acc == C64_RD), .ack(dma_ack), .q(dma_q),
        .req(dma_req), .addr(dma_a), .data(dma_d), .dir(dma_rw),
        .rdata(dma_rdata), .ack_seen(dma_seen)
    );

    reu_bus_port #(.A_W(ram_a_bits), .DIR_RST(1'b0), .RD_DIR(1'b0)) u_ram_port (
        .clk(clk), .reset(reset), .go(go_ram), .addr_in(ram_addr_next),
        .data_in(dma_rdata), .dir_in(acc == RAM_WR), .ack(ram_ack), .q(ram_q),
        .req(ram_req), .addr(ram_a), .data(ram_d), .dir(ram_we),
        .rdata(ram_rdata), .ack_seen(ram_seen)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            after_gap <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            after_gap <= after_n;
            busy      <= (state_n != IDLE);
            done      <= finish;
            fault     <= finish && mismatch;
        end
    end

    always_comb begin
        state_n = state;
        after_n = after_gap;
        case (state)
            IDLE: if (start) state_n = first_access(ttype);
            GAP:  state_n = after_gap;
            default: begin
                if (finish) begin
                    state_n = IDLE;
                end else if (ack_now) begin
                    state_n = GAP;
                    after_n = byte_end ? first_access(tt) : next_access(state, tt);
                end
            end
        endcase
    end

    // In IDLE the first access is launched straight from the start inputs.
    always_comb begin
        launch   = (state == IDLE) && start;
        acc      = (state == IDLE) ? first_access(ttype) : after_gap;
        go_c64   = (launch || state == GAP) && (acc == C64_RD || acc == C64_WR);
        go_ram   = (launch || state == GAP) && (acc == RAM_RD || acc == RAM_WR);
        ack_now  = ((state == C64_RD || state == C64_WR) && dma_seen) ||
                   ((state == RAM_RD || state == RAM_WR) && ram_seen);
        byte_end = ack_now && is_last(state, tt);
        mismatch = byte_end && (tt == TT_VERIFY) && (ram_q != dma_rdata);
        finish   = byte_end && ((len_cur == 16'd1) || mismatch);
        c64_addr_next = launch ? c64_a_in : c64_a_cur;
        ram_addr_next = launch ? ram_a_in : ram_a_cur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c64_a_cur <= '0;
            ram_a_cur <= '0;
            len_cur   <= 16'hFFFF;
            tt        <= TT_STASH;
            fix_c64_q <= 1'b0;
            fix_ram_q <= 1'b0;
        end else if (launch) begin
            c64_a_cur <= c64_a_in;
            ram_a_cur <= ram_a_in;
            len_cur   <= len_in;
            tt        <= ttype;
            fix_c64_q <= fix_c64;
            fix_ram_q <= fix_ram;
        end else if (byte_end) begin
            if (!fix_c64_q) c64_a_cur <= c64_a_cur + 16'd1;
            if (!fix_ram_q) ram_a_cur <= ram_a_cur + RAM_ONE;
            // A length of 0 counts through FFFF so it yields 65536 bytes.
            if (len_cur != 16'd1) len_cur <= len_cur - 16'd1;
        end
    end

endmodule

// File: tb/tb_reu_transfer_sequencer.sv
// Directed bench for reu_transfer_sequencer with simple C64/RAM bus responders
// that log every completed access.
module tb_reu_transfer_sequencer;

    localparam int RAB = 17;

    logic clk = 1'b0;
    logic reset, start, fix_c64, fix_ram;
    logic [1:0] ttype;
    logic [15:0] c64_a_in, len_in;
    logic [RAB-1:0] ram_a_in;
    logic busy, done, fault;
    logic [15:0] c64_a_cur, len_cur, dma_a;
    logic [RAB-1:0] ram_a_cur, ram_a;
    logic [7:0] dma_d, dma_q, ram_d, ram_q;
    logic dma_rw, dma_req, dma_ack, ram_we, ram_req, ram_ack;

    logic [7:0] c64_mem [0:65535];
    logic [7:0] ram_mem [0:(1<<RAB)-1];
    int ack_dly = 0;
    int dcnt = 0, rcnt = 0;

    logic [1:0]     log_kind [0:63];
    logic [RAB-1:0] log_addr [0:63];
    logic [7:0]     log_data [0:63];
    int             log_hold [0:63];
    int nlog = 0;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    reu_transfer_sequencer #(.ram_a_bits(RAB)) dut (
        .clk(clk), .reset(reset), .start(start), .ttype(ttype),
        .c64_a_in(c64_a_in), .ram_a_in(ram_a_in), .len_in(len_in),
        .fix_c64(fix_c64), .fix_ram(fix_ram),
        .busy(busy), .done(done), .fault(fault),
        .c64_a_cur(c64_a_cur), .ram_a_cur(ram_a_cur), .len_cur(len_cur),
        .dma_a(dma_a), .dma_d(dma_d), .dma_q(dma_q), .dma_rw(dma_rw),
        .dma_req(dma_req), .dma_ack(dma_ack),
        .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q), .ram_we(ram_we),
        .ram_req(ram_req), .ram_ack(ram_ack)
    );

    assign dma_q   = c64_mem[dma_a];
    assign ram_q   = ram_mem[ram_a];
    assign dma_ack = dma_req && (dcnt >= ack_dly);
    assign ram_ack = ram_req && (rcnt >= ack_dly);

    // kind = {is_ram, is_write}; data is the read or written byte
    always @(posedge clk) begin
        dcnt <= dma_req ? dcnt + 1 : 0;
        rcnt <= ram_req ? rcnt + 1 : 0;
        if (nlog < 64) begin
            if (dma_req && dma_ack) begin
                log_kind[nlog] <= {1'b0, ~dma_rw};
                log_addr[nlog] <= {1'b0, dma_a};
                log_data[nlog] <= dma_rw ? dma_q : dma_d;
                log_hold[nlog] <= dcnt + 1;
                nlog <= nlog + 1;
            end else if (ram_req && ram_ack) begin
                log_kind[nlog] <= {1'b1, ram_we};
                log_addr[nlog] <= ram_a;
                log_data[nlog] <= ram_we ? ram_d : ram_q;
                log_hold[nlog] <= rcnt + 1;
                nlog <= nlog + 1;
            end
        end
    end

    function automatic logic [31:0] rec(input int i);
        return {5'd0, log_kind[i], log_addr[i], log_data[i]};
    endfunction

    function automatic logic [31:0] mk(input logic [1:0] k, input logic [RAB-1:0] a,
                                       input logic [7:0] d);
        return {5'd0, k, a, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] t, input logic [15:0] ca, input logic [RAB-1:0] ra,
                          input logic [15:0] l, input logic fc, input logic fr);
        ttype = t; c64_a_in = ca; ram_a_in = ra; len_in = l; fix_c64 = fc; fix_ram = fr;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int first, input int limit, output int cyc);
        cyc = first;
        while (!done && cyc < limit) begin
            tick();
            cyc++;
        end
        chk("done_seen", 32'(done), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, base, n;
        reset = 1'b1; start = 1'b0; ttype = 2'd0; c64_a_in = '0; ram_a_in = '0;
        len_in = '0; fix_c64 = 1'b0; fix_ram = 1'b0;

        c64_mem[16'hC000] = 8'h11; c64_mem[16'hC001] = 8'h22; c64_mem[16'hC002] = 8'h33;
        ram_mem[17'h00100] = 8'h05; ram_mem[17'h00101] = 8'h06;
        c64_mem[16'h2000] = 8'hAA; ram_mem[17'h00200] = 8'h55;
        c64_mem[16'h3000] = 8'h01; c64_mem[16'h3001] = 8'h02;
        c64_mem[16'h3002] = 8'h03; c64_mem[16'h3003] = 8'h04;
        ram_mem[17'h00300] = 8'h01; ram_mem[17'h00301] = 8'h0F;
        ram_mem[17'h00302] = 8'h03; ram_mem[17'h00303] = 8'h04;
        c64_mem[16'h4000] = 8'h9A; c64_mem[16'h4001] = 8'hBC;
        c64_mem[16'hFFFF] = 8'h77; c64_mem[16'h0000] = 8'h88;

        // reset values, and start ignored while reset is high
        tick(); tick();
        ttype = 2'd0; c64_a_in = 16'h1234; ram_a_in = 17'h00055; len_in = 16'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_dma_req", 32'(dma_req), 0);
        chk("rst_ram_req", 32'(ram_req), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_dma_rw", 32'(dma_rw), 1);
        chk("rst_dma_a", 32'(dma_a), 0);
        chk("rst_ram_a", 32'(ram_a), 0);
        chk("rst_dma_d", 32'(dma_d), 0);
        chk("rst_ram_d", 32'(ram_d), 0);
        chk("rst_c64_a_cur", 32'(c64_a_cur), 0);
        chk("rst_ram_a_cur", 32'(ram_a_cur), 0);
        chk("rst_len_cur", 32'(len_cur), 'hFFFF);
        reset = 1'b0;
        tick();

        // stash 3 bytes C000 -> 00010, acks immediate
        base = nlog;
        launch(2'd0, 16'hC000, 17'h00010, 16'd3, 1'b0, 1'b0);
        chk("stash_busy", 32'(busy), 1);
        chk("stash_first_req", 32'(dma_req), 1);
        chk("stash_first_a", 32'(dma_a), 'hC000);
        chk("stash_first_rw", 32'(dma_rw), 1);
        chk("stash_ram_req_low", 32'(ram_req), 0);
        wait_done(1, 40, cyc);
        chk("stash_cycles", 32'(cyc), 12);
        chk("stash_busy_end", 32'(busy), 0);
        chk("stash_c64_a_cur", 32'(c64_a_cur), 'hC003);
        chk("stash_ram_a_cur", 32'(ram_a_cur), 'h13);
        chk("stash_len_cur", 32'(len_cur), 1);
        chk("stash_wr0", rec(base + 1), mk(2'd3, 17'h10, 8'h11));
        chk("stash_wr1", rec(base + 3), mk(2'd3, 17'h11, 8'h22));
        chk("stash_wr2", rec(base + 5), mk(2'd3, 17'h12, 8'h33));
        tick();
        chk("stash_done_pulse", 32'(done), 0);

        // fetch 2 bytes to fixed D020, ack delayed 3 cycles
        ack_dly = 3;
        base = nlog;
        launch(2'd1, 16'hD020, 17'h00100, 16'd2, 1'b1, 1'b0);
        wait_done(1, 100, cyc);
        chk("fetch_cycles", 32'(cyc), 20);
        chk("fetch_wr0", rec(base + 1), mk(2'd1, 17'h0D020, 8'h05));
        chk("fetch_wr1", rec(base + 3), mk(2'd1, 17'h0D020, 8'h06));
        chk("fetch_hold_rd", 32'(log_hold[base]), 4);
        chk("fetch_hold_wr", 32'(log_hold[base + 1]), 4);
        chk("fetch_c64_a_cur", 32'(c64_a_cur), 'hD020);
        chk("fetch_ram_a_cur", 32'(ram_a_cur), 'h102);
        chk("fetch_len_cur", 32'(len_cur), 1);
        ack_dly = 0;
        tick();

        // swap 1 byte: C64 2000=AA, RAM 00200=55
        base = nlog;
        launch(2'd2, 16'h2000, 17'h00200, 16'd1, 1'b0, 1'b0);
        wait_done(1, 40, cyc);
        chk("swap_cycles", 32'(cyc), 8);
        chk("swap_order", 32'({log_kind[base], log_kind[base + 1], log_kind[base + 2],
                                log_kind[base + 3]}), 'b00_10_11_01);
        chk("swap_ram_wr", rec(base + 2), mk(2'd3, 17'h00200, 8'hAA));
        chk("swap_c64_wr", rec(base + 3), mk(2'd1, 17'h02000, 8'h55));
        tick();

        // verify 4 bytes, second byte differs
        launch(2'd3, 16'h3000, 17'h00300, 16'd4, 1'b0, 1'b0);
        wait_done(1, 40, cyc);
        chk("verify_cycles", 32'(cyc), 8);
        chk("verify_fault", 32'(fault), 1);
        chk("verify_len_cur", 32'(len_cur), 2);
        chk("verify_c64_a_cur", 32'(c64_a_cur), 'h3002);
        chk("verify_ram_a_cur", 32'(ram_a_cur), 'h302);
        tick();
        chk("verify_fault_pulse", 32'(fault), 0);
        chk("verify_idle", 32'(busy), 0);

        // start while busy must not disturb a running stash
        base = nlog;
        launch(2'd0, 16'h4000, 17'h00400, 16'd2, 1'b0, 1'b0);
        tick(); tick();
        ttype = 2'd1; c64_a_in = 16'h5000; ram_a_in = 17'h00777; len_in = 16'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(4, 40, cyc);
        chk("busy_start_cycles", 32'(cyc), 8);
        chk("busy_start_c64_a", 32'(c64_a_cur), 'h4002);
        chk("busy_start_ram_a", 32'(ram_a_cur), 'h402);
        chk("busy_start_len", 32'(len_cur), 1);
        chk("busy_start_wr0", rec(base + 1), mk(2'd3, 17'h400, 8'h9A));
        chk("busy_start_wr1", rec(base + 3), mk(2'd3, 17'h401, 8'hBC));
        chk("busy_start_count", 32'(nlog - base), 4);
        tick();

        // len=0 with both addresses at all-ones, aborted by reset after 5 bytes
        base = nlog;
        launch(2'd0, 16'hFFFF, 17'h1FFFF, 16'd0, 1'b0, 1'b0);
        n = 0;
        while ((nlog - base) < 10 && n < 100) begin
            tick();
            n++;
        end
        chk("wrap_accesses", 32'(nlog - base), 10);
        chk("wrap_rd0", rec(base), mk(2'd0, 17'h0FFFF, 8'h77));
        chk("wrap_wr0", rec(base + 1), mk(2'd3, 17'h1FFFF, 8'h77));
        chk("wrap_rd1", rec(base + 2), mk(2'd0, 17'h00000, 8'h88));
        chk("wrap_wr1", rec(base + 3), mk(2'd3, 17'h00000, 8'h88));
        chk("wrap_len_cur", 32'(len_cur), 'hFFFB);
        chk("wrap_c64_a_cur", 32'(c64_a_cur), 'h0004);
        chk("wrap_ram_a_cur", 32'(ram_a_cur), 'h00004);
        chk("wrap_busy", 32'(busy), 1);
        tick();
        chk("abort_req_before", 32'(dma_req), 1);
        reset = 1'b1;
        tick();
        chk("abort_dma_req", 32'(dma_req), 0);
        chk("abort_ram_req", 32'(ram_req), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("abort_no_done", 32'(done), 0);
        chk("abort_len_cur", 32'(len_cur), 'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
